// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle controller and the RV32I datapath.
// master: the controller (reads instruction fields / flags, drives control).
// slave:  the datapath (drives instruction fields / flags, reads control).
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] imm_src;
    logic [1:0] result_src;
    logic [2:0] alu_op;
    logic [3:0] state;
    logic       illegal;

    modport master (
        input  op, funct3, zero, mem_ready,
        output mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, imm_src, result_src, alu_op, state, illegal
    );

    modport slave (
        output op, funct3, zero, mem_ready,
        input  mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, imm_src, result_src, alu_op, state, illegal
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the shared-memory RV32I core.
// Sequences fetch/decode/execute/memory/writeback, drives datapath selects,
// waits on a variable-latency memory, and traps on unsupported opcodes.
// Optional macro PERF_CNT_EN adds cycle_cnt / instret_cnt outputs.
module multicycle_controller #(
    parameter int RESET_PC_HOLD = 1
) (
    input  logic clk,
    input  logic rst_n,
    multicycle_controller_if.master bus
`ifdef PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECR    = 4'd7,
        S_EXECI    = 4'd8,
        S_ALUWB    = 4'd9,
        S_BRANCH   = 4'd10,
        S_JAL      = 4'd11,
        S_JALR     = 4'd12,
        S_LUI      = 4'd13,
        S_AUIPC    = 4'd14,
        S_TRAP     = 4'd15
    } state_e;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    // Last hold-counter value seen in RESET before moving on to FETCH.
    localparam logic [3:0] HOLD_LAST = 4'(RESET_PC_HOLD - 1);

    state_e     state_q, state_d;
    logic [3:0] hold_q, hold_d;

    logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, illegal;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [2:0] imm_src, alu_op;
    logic       taken;

    // beq/bge/bgeu take on zero; bne/blt/bltu take on !zero (ALU gives 1 on less).
    assign taken = zero_inv_sel() ? ~bus.zero : bus.zero;

    function automatic logic zero_inv_sel();
        return bus.funct3[2] ^ bus.funct3[0];
    endfunction

    // State register and post-reset hold counter; reset lands in RESET at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RESET;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // Next-state and state-decoded control outputs (Moore, except FETCH/BRANCH writes).
    always_comb begin
        state_d    = state_q;
        hold_d     = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        imm_src    = 3'b000;
        result_src = 2'b00;
        alu_op     = 3'b000;
        illegal    = 1'b0;
        case (state_q)
            S_RESET: begin
                hold_d = hold_q + 4'd1;
                if (hold_q == HOLD_LAST) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = bus.mem_ready;
                pc_write   = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Branch/jump target is precomputed into ALUOut here.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = (bus.op == OP_JAL) ? 3'b011 : 3'b010;
                case (bus.op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_I:              state_d = S_EXECI;
                    OP_BR:             state_d = (bus.funct3[2:1] == 2'b01) ? S_TRAP : S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_src   = (bus.op == OP_STORE) ? 3'b001 : 3'b000;
                state_d   = (bus.op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                adr_src = 1'b1;
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 3'b010;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 3'b010;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = 3'b001;
                pc_write  = taken;
                state_d   = S_FETCH;
            end
            S_JAL: begin
                // PC <- ALUOut (target); ALU computes OldPC+4 for the link write.
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                state_d   = S_ALUWB;
            end
            S_JALR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = S_JAL;
            end
            S_LUI: begin
                imm_src    = 3'b100;
                result_src = 2'b11;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_AUIPC: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = 3'b100;
                state_d   = S_ALUWB;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: state_d = S_TRAP;
        endcase
    end

    assign bus.mem_req    = mem_req;
    assign bus.mem_we     = mem_we;
    assign bus.adr_src    = adr_src;
    assign bus.ir_write   = ir_write;
    assign bus.pc_write   = pc_write;
    assign bus.reg_write  = reg_write;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.imm_src    = imm_src;
    assign bus.result_src = result_src;
    assign bus.alu_op     = alu_op;
    assign bus.state      = state_q;
    assign bus.illegal    = illegal;

`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] instret_cnt_q, instret_cnt_d;

    // Cycles outside RESET; retirements are entries into FETCH from a real instruction.
    always_comb begin
        cycle_cnt_d   = cycle_cnt_q;
        instret_cnt_d = instret_cnt_q;
        if (state_q != S_RESET) cycle_cnt_d = cycle_cnt_q + 32'd1;
        if (state_d == S_FETCH && state_q != S_FETCH && state_q != S_RESET)
            instret_cnt_d = instret_cnt_q + 32'd1;
    end

    // Performance counter registers, wrap modulo 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: random instruction stream,
// per-instruction expected state/control sequences pushed to a queue,
// popped and compared by an independent negedge monitor.
module tb_multicycle_controller;

    localparam int HOLD = 1;

    typedef struct packed {
        logic [3:0] st;
        logic       req, we, adr, irw, pcw, rw;
        logic [1:0] a, b;
        logic [2:0] imm;
        logic [1:0] rs;
        logic [2:0] aop;
        logic       ill;
    } ctl_t;

    typedef struct packed {
        ctl_t        c;
        logic [31:0] cyc;
        logic [31:0] ins;
    } exp_t;

    logic clk;
    logic rst_n;
    multicycle_controller_if bus();
`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    multicycle_controller #(.RESET_PC_HOLD(HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef PERF_CNT_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_cyc = 0;
    logic [31:0] m_ins = 0;

    // ---------------- reference model helpers ----------------
    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic ctl_t idle(input logic [3:0] st);
        ctl_t c;
        c = '0;
        c.st = st;
        return c;
    endfunction

    // One clock of stimulus: drive flags, queue what must be seen this cycle.
    task automatic cyc(input ctl_t c, input logic mr, input logic zf, input bit last);
        exp_t e;
        bus.mem_ready = mr;
        bus.zero      = zf;
        e.c   = c;
        e.cyc = m_cyc;
        e.ins = m_ins;
        sb.push_back(e);
        @(posedge clk); #1;
        if (rst_n && c.st != 4'd0) m_cyc++;
        if (last) m_ins++;
    endtask

    // Memory access with a random number of not-ready cycles before completion.
    task automatic mem_access(input ctl_t c, input bit last);
        int w;
        w = $urandom_range(0, 3);
        for (int i = 0; i < w; i++) cyc(c, 1'b0, rb(), 1'b0);
        cyc(c, 1'b1, rb(), last);
    endtask

    task automatic fetch();
        ctl_t c;
        int   w;
        c = idle(4'd1); c.req = 1; c.b = 2'd2; c.rs = 2'd2;
        w = $urandom_range(0, 3);
        for (int i = 0; i < w; i++) cyc(c, 1'b0, rb(), 1'b0);
        c.irw = 1; c.pcw = 1;
        cyc(c, 1'b1, rb(), 1'b0);
    endtask

    task automatic decode();
        ctl_t c;
        c = idle(4'd2); c.a = 2'd1; c.b = 2'd1;
        c.imm = (bus.op == 7'b1101111) ? 3'd3 : 3'd2;
        cyc(c, rb(), rb(), 1'b0);
    endtask

    task automatic aluwb();
        ctl_t c;
        c = idle(4'd9); c.rw = 1;
        cyc(c, rb(), rb(), 1'b1);
    endtask

    task automatic jal_step();
        ctl_t c;
        c = idle(4'd11); c.a = 2'd1; c.b = 2'd2; c.pcw = 1;
        cyc(c, rb(), rb(), 1'b0);
        aluwb();
    endtask

    // One whole instruction of the given class, from FETCH to its last state.
    task automatic run(input int kind);
        ctl_t        c;
        logic [2:0]  f3;
        logic        zf;
        bit          tk;
        f3 = 3'($urandom);
        case (kind)
            0: bus.op = 7'b0000011;
            1: bus.op = 7'b0100011;
            2: bus.op = 7'b0110011;
            3: bus.op = 7'b0010011;
            4: begin
                bus.op = 7'b1100011;
                while (f3 == 3'd2 || f3 == 3'd3) f3 = 3'($urandom);
            end
            5: bus.op = 7'b1101111;
            6: bus.op = 7'b1100111;
            7: bus.op = 7'b0110111;
            default: bus.op = 7'b0010111;
        endcase
        bus.funct3 = f3;
        fetch();
        decode();
        case (kind)
            0: begin
                c = idle(4'd3); c.a = 2'd2; c.b = 2'd1; c.imm = 3'd0;
                cyc(c, rb(), rb(), 1'b0);
                c = idle(4'd4); c.req = 1; c.adr = 1;
                mem_access(c, 1'b0);
                c = idle(4'd5); c.rs = 2'd1; c.rw = 1;
                cyc(c, rb(), rb(), 1'b1);
            end
            1: begin
                c = idle(4'd3); c.a = 2'd2; c.b = 2'd1; c.imm = 3'd1;
                cyc(c, rb(), rb(), 1'b0);
                c = idle(4'd6); c.req = 1; c.we = 1; c.adr = 1;
                mem_access(c, 1'b1);
            end
            2: begin
                c = idle(4'd7); c.a = 2'd2; c.aop = 3'd2;
                cyc(c, rb(), rb(), 1'b0);
                aluwb();
            end
            3: begin
                c = idle(4'd8); c.a = 2'd2; c.b = 2'd1; c.aop = 3'd2;
                cyc(c, rb(), rb(), 1'b0);
                aluwb();
            end
            4: begin
                zf = rb();
                case (f3)
                    3'd0, 3'd5, 3'd7: tk = zf;   // beq, bge, bgeu
                    default:          tk = !zf;  // bne, blt, bltu
                endcase
                c = idle(4'd10); c.a = 2'd2; c.aop = 3'd1; c.pcw = tk;
                cyc(c, rb(), zf, 1'b1);
            end
            5: jal_step();
            6: begin
                c = idle(4'd12); c.a = 2'd2; c.b = 2'd1;
                cyc(c, rb(), rb(), 1'b0);
                jal_step();
            end
            7: begin
                c = idle(4'd13); c.imm = 3'd4; c.rs = 2'd3; c.rw = 1;
                cyc(c, rb(), rb(), 1'b1);
            end
            default: begin
                c = idle(4'd14); c.a = 2'd1; c.b = 2'd1; c.imm = 3'd4;
                cyc(c, rb(), rb(), 1'b0);
                aluwb();
            end
        endcase
    endtask

    // Unsupported instruction: decode, then TRAP held for n cycles.
    task automatic trap(input logic [6:0] op, input logic [2:0] f3, input int n);
        ctl_t c;
        bus.op = op;
        bus.funct3 = f3;
        fetch();
        decode();
        c = idle(4'd15); c.ill = 1;
        for (int i = 0; i < n; i++) cyc(c, rb(), rb(), 1'b0);
    endtask

    // Reset asserted for n cycles, then the RESET hold cycles after release.
    task automatic do_reset(input int n);
        rst_n = 1'b0;
        m_cyc = 0;
        m_ins = 0;
        for (int i = 0; i < n; i++) cyc(idle(4'd0), rb(), rb(), 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < HOLD; i++) cyc(idle(4'd0), rb(), rb(), 1'b0);
    endtask

    // ---------------- monitor ----------------
    exp_t e_mon;
    ctl_t a_mon;

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            e_mon = sb.pop_front();
            a_mon = {bus.state, bus.mem_req, bus.mem_we, bus.adr_src, bus.ir_write,
                     bus.pc_write, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
                     bus.imm_src, bus.result_src, bus.alu_op, bus.illegal};
            n_cmp++;
            if (a_mon !== e_mon.c) begin
                n_bad++;
                $display("FAIL ctl t=%0t: got %h required %h (state got %0d required %0d)",
                         $time, a_mon, e_mon.c, a_mon.st, e_mon.c.st);
            end
`ifdef PERF_CNT_EN
            n_cmp++;
            if (cycle_cnt !== e_mon.cyc) begin
                n_bad++;
                $display("FAIL cycle_cnt t=%0t: got %0d required %0d", $time, cycle_cnt, e_mon.cyc);
            end
            n_cmp++;
            if (instret_cnt !== e_mon.ins) begin
                n_bad++;
                $display("FAIL instret_cnt t=%0t: got %0d required %0d", $time, instret_cnt, e_mon.ins);
            end
`endif
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        bus.op = '0;
        bus.funct3 = '0;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;
        @(posedge clk); #1;
        do_reset(2);
        for (int k = 0; k < 9; k++) run(k);
        repeat (60) run($urandom_range(0, 8));
        trap(7'b1100011, 3'b010, 3);
        do_reset(1);
        run(0);
        run(1);
        trap(7'b0000000, 3'($urandom), 4);
        do_reset(1);
        repeat (3) run(2);
        trap(7'b1111111, 3'($urandom), 2);
        @(negedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
